acq_buf: RTL and testbench

Stream-to-buffer acquisition engine: the receive-side counterpart of the arbitrary signal generator. It captures an ADC sample stream into a circular on-chip buffer, with pre-trigger and post-trigger sample counts, a masked external/software trigger, and CPU readback of configuration, status and buffer contents over a simple register bus. It sits between the ADC front-end stream and the system bus, beside the generator. Its trigger output and interrupts feed the same trigger fabric the generator uses.

---
 rtl/acq_buf_if.sv | 28 ++
 rtl/acq_buf.sv | 225 ++++++++++++++++++++++
 tb/tb_acq_buf.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_buf_if.sv
// acq_buf_if: sample stream and register-bus bundle for the acquisition engine.
//   sti_tvalid/sti_tdata/sti_tready : ADC sample stream (never back-pressured)
//   bus_wen/bus_ren/bus_addr/bus_wdata : single-cycle CPU access strobes
//   bus_rdata/bus_ack                  : response, one cycle after the strobe
// master = stream source / CPU side, slave = acq_buf.
interface acq_buf_if #(
  parameter int DW = 14
);
  logic                 sti_tvalid;
  logic signed [DW-1:0] sti_tdata;
  logic                 sti_tready;
  logic                 bus_wen;
  logic                 bus_ren;
  logic [31:0]          bus_addr;
  logic [31:0]          bus_wdata;
  logic [31:0]          bus_rdata;
  logic                 bus_ack;

  modport master (
    output sti_tvalid, sti_tdata, bus_wen, bus_ren, bus_addr, bus_wdata,
    input  sti_tready, bus_rdata, bus_ack
  );

  modport slave (
    input  sti_tvalid, sti_tdata, bus_wen, bus_ren, bus_addr, bus_wdata,
    output sti_tready, bus_rdata, bus_ack
  );
endinterface

// File: rtl/acq_buf.sv
// acq_buf: stream-to-buffer acquisition engine.
// Captures an ADC sample stream into a circular buffer of 2^AW samples with
// pre-trigger and post-trigger counts and a masked external/software trigger.
// Configuration, status and buffer contents are read back over a register bus.
// Ports:
//   clk, rst  : single clock, synchronous active-high reset
//   bif       : acq_buf_if.slave (sample stream + register bus)
//   trg_ext   : external trigger levels, qualified by the trigger mask
//   trg_out   : one-cycle pulse on the accepted trigger
//   irq_trg   : one-cycle pulse on the accepted trigger
//   irq_stp   : one-cycle pulse when an acquisition completes
// Bus map: bus_addr[AW+2]=1 selects the buffer (word index bus_addr[AW+1:2]),
// otherwise registers decoded on bus_addr[5:0].
module acq_buf #(
  parameter int DW = 14,
  parameter int AW = 14,
  parameter int CW = 32,
  parameter int TN = 4
) (
  input  logic          clk,
  input  logic          rst,
  acq_buf_if.slave      bif,
  input  logic [TN-1:0] trg_ext,
  output logic          trg_out,
  output logic          irq_trg,
  output logic          irq_stp
);

  typedef enum logic [1:0] {IDLE, PRE, ARMED, POST} state_t;

  localparam logic [5:0] OFS_CTL = 6'h00;
  localparam logic [5:0] OFS_TRG = 6'h04;
  localparam logic [5:0] OFS_PRE = 6'h10;
  localparam logic [5:0] OFS_PST = 6'h14;
  localparam logic [5:0] OFS_TPT = 6'h18;
  localparam logic [5:0] OFS_PTR = 6'h1c;

  // Buffer words are two's complement samples; the bus sees them widened.
  function automatic logic [31:0] sext(input logic signed [DW-1:0] s);
    return {{(32-DW){s[DW-1]}}, s};
  endfunction

  state_t               state, state_nxt;
  logic [AW-1:0]        ptr, ptr_nxt;
  logic [AW-1:0]        trg_ptr, trg_ptr_nxt;
  logic [CW-1:0]        pre_cnt, pre_cnt_nxt;
  logic [CW-1:0]        post_cnt, post_cnt_nxt;
  logic [CW:0]          post_inc;
  logic                 trg_pls, trg_pls_nxt;
  logic                 stp_pls, stp_pls_nxt;
  logic                 mem_we;
  logic                 run;
  logic                 hw_trg;

  logic [TN-1:0]        cfg_trg;
  logic [CW-1:0]        cfg_pre;
  logic [CW-1:0]        cfg_pst;

  logic                 sel_buf_p0;
  logic [5:0]           ofs_p0;
  logic                 wr_reg_p0;
  logic                 eng_rst_p0;
  logic                 start_p0;
  logic                 sw_trg_p0;
  logic [31:0]          reg_rd_p0;

  logic                 vld_p1;
  logic                 sel_buf_p1;
  logic [31:0]          reg_rd_p1;
  logic signed [DW-1:0] ram_q_p1;

  logic signed [DW-1:0] mem [2**AW];

  logic                 addr_unused;

  // ---- stage p0: bus strobe decode ----
  assign sel_buf_p0 = bif.bus_addr[AW+2];
  assign ofs_p0     = bif.bus_addr[5:0];
  assign wr_reg_p0  = bif.bus_wen && !sel_buf_p0;
  assign eng_rst_p0 = wr_reg_p0 && (ofs_p0 == OFS_CTL) && bif.bus_wdata[0];
  assign start_p0   = wr_reg_p0 && (ofs_p0 == OFS_CTL) && bif.bus_wdata[1];
  assign sw_trg_p0  = wr_reg_p0 && (ofs_p0 == OFS_CTL) && bif.bus_wdata[2];

  assign addr_unused = ^{bif.bus_addr[31:AW+3], bif.bus_addr[1:0], bif.bus_wdata};

  assign run      = (state != IDLE);
  assign hw_trg   = |(trg_ext & cfg_trg);
  assign post_inc = {1'b0, post_cnt} + {{CW{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_trg <= '0;
      cfg_pre <= '0;
      cfg_pst <= '0;
    end else if (wr_reg_p0) begin
      case (ofs_p0)
        OFS_TRG: cfg_trg <= bif.bus_wdata[TN-1:0];
        OFS_PRE: cfg_pre <= bif.bus_wdata[CW-1:0];
        OFS_PST: cfg_pst <= bif.bus_wdata[CW-1:0];
        default: ;
      endcase
    end
  end

  // Next-state and counter logic. The pre/post comparisons use >= against the
  // live configuration so a count lowered while running still terminates.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    trg_ptr_nxt  = trg_ptr;
    pre_cnt_nxt  = pre_cnt;
    post_cnt_nxt = post_cnt;
    trg_pls_nxt  = 1'b0;
    stp_pls_nxt  = 1'b0;
    mem_we       = 1'b0;

    if (run && bif.sti_tvalid) begin
      mem_we  = 1'b1;
      ptr_nxt = ptr + AW'(1);
    end

    case (state)
      IDLE: begin
        if (start_p0) begin
          state_nxt   = PRE;
          ptr_nxt     = '0;
          pre_cnt_nxt = '0;
        end
      end
      PRE: begin
        if (bif.sti_tvalid) pre_cnt_nxt = pre_cnt + CW'(1);
        if (pre_cnt >= cfg_pre) state_nxt = ARMED;
      end
      ARMED: begin
        if (hw_trg || sw_trg_p0) begin
          state_nxt    = POST;
          trg_ptr_nxt  = ptr;
          post_cnt_nxt = '0;
          trg_pls_nxt  = 1'b1;
        end
      end
      POST: begin
        if (bif.sti_tvalid) post_cnt_nxt = post_cnt + CW'(1);
        if ((post_cnt >= cfg_pst) ||
            (bif.sti_tvalid && (post_inc >= {1'b0, cfg_pst}))) begin
          state_nxt   = IDLE;
          stp_pls_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Engine reset overrides everything, including a start in the same write,
    // and aborts silently without a stop interrupt.
    if (eng_rst_p0) begin
      state_nxt    = IDLE;
      ptr_nxt      = '0;
      pre_cnt_nxt  = '0;
      post_cnt_nxt = '0;
      trg_pls_nxt  = 1'b0;
      stp_pls_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      trg_ptr  <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      trg_pls  <= 1'b0;
      stp_pls  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      trg_ptr  <= trg_ptr_nxt;
      pre_cnt  <= pre_cnt_nxt;
      post_cnt <= post_cnt_nxt;
      trg_pls  <= trg_pls_nxt;
      stp_pls  <= stp_pls_nxt;
    end
  end

  always_comb begin
    reg_rd_p0 = '0;
    case (ofs_p0)
      OFS_CTL: reg_rd_p0 = {30'b0, ~run, run};
      OFS_TRG: reg_rd_p0 = 32'(cfg_trg);
      OFS_PRE: reg_rd_p0 = 32'(cfg_pre);
      OFS_PST: reg_rd_p0 = 32'(cfg_pst);
      OFS_TPT: reg_rd_p0 = 32'(trg_ptr);
      OFS_PTR: reg_rd_p0 = 32'(ptr);
      default: reg_rd_p0 = '0;
    endcase
  end

  // ---- stage p1: registered buffer read port and bus response ----
  // Write and read share one block so a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= bif.sti_tdata;
    ram_q_p1 <= mem[bif.bus_addr[AW+1:2]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      sel_buf_p1 <= 1'b0;
      reg_rd_p1  <= '0;
    end else begin
      vld_p1     <= bif.bus_wen || bif.bus_ren;
      sel_buf_p1 <= bif.bus_ren && sel_buf_p0;
      reg_rd_p1  <= (bif.bus_ren && !sel_buf_p0) ? reg_rd_p0 : '0;
    end
  end

  assign bif.bus_ack    = vld_p1;
  assign bif.bus_rdata  = sel_buf_p1 ? sext(ram_q_p1) : reg_rd_p1;
  assign bif.sti_tready = 1'b1;

  assign trg_out = trg_pls;
  assign irq_trg = trg_pls;
  assign irq_stp = stp_pls;

endmodule

// File: tb/tb_acq_buf.sv
// tb_acq_buf: directed bench for acq_buf (AW=4 so wrap-around is reachable).
// Bus reads push their expected word into a queue; a negedge monitor pops and
// compares on every bus_ack and records trigger/stop pulse cycles.
module tb_acq_buf;
  localparam int DW = 14;
  localparam int AW = 4;
  localparam int CW = 32;
  localparam int TN = 4;
  localparam logic [31:0] BUF = 32'h40;

  logic          clk = 1'b0;
  logic          rst;
  logic [TN-1:0] trg_ext;
  logic          trg_out;
  logic          irq_trg;
  logic          irq_stp;

  acq_buf_if #(.DW(DW)) bif ();

  acq_buf #(.DW(DW), .AW(AW), .CW(CW), .TN(TN)) dut (
    .clk    (clk),
    .rst    (rst),
    .bif    (bif),
    .trg_ext(trg_ext),
    .trg_out(trg_out),
    .irq_trg(irq_trg),
    .irq_stp(irq_stp)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle = cycle + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  bit          chk_q[$];
  string       name_q[$];

  int trg_cnt = 0, stp_cnt = 0, trg_cycle = 0, stp_cycle = 0;
  logic [31:0] m_exp;
  bit          m_chk;
  string       m_name;

  // stream generator state, advanced by cyc()
  bit            stream_en = 0;
  int            samp = 0, base = 0, gap = 1, phase = 0, trg_a = -1, trg_b = -1;
  logic [TN-1:0] trg_bits = '0, trg_hold = '0;
  int            samp_cycle[64];
  int            wr_cycle = 0;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (trg_out !== irq_trg) begin
        errors++;
        $display("FAIL trg_out_vs_irq_trg: trg_out=%b irq_trg=%b cycle %0d", trg_out, irq_trg, cycle);
      end
      if (irq_trg === 1'b1) begin trg_cnt++; trg_cycle = cycle; end
      if (irq_stp === 1'b1) begin stp_cnt++; stp_cycle = cycle; end
      if (bif.bus_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: ack with no pending access, cycle %0d", cycle);
        end else begin
          m_exp = exp_q.pop_front();
          m_chk = chk_q.pop_front();
          m_name = name_q.pop_front();
          if (m_chk) begin
            checks++;
            if (bif.bus_rdata !== m_exp) begin
              errors++;
              $display("FAIL %s: got 0x%08h expected 0x%08h", m_name, bif.bus_rdata, m_exp);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    bif.bus_wen    = 1'b0;
    bif.bus_ren    = 1'b0;
    bif.sti_tvalid = 1'b0;
    trg_ext        = trg_hold;
    if (stream_en) begin
      if (phase == 0) begin
        bif.sti_tvalid = 1'b1;
        bif.sti_tdata  = DW'(samp + base);
        if (samp == trg_a || samp == trg_b) trg_ext = trg_hold | trg_bits;
        if (samp < 64) samp_cycle[samp] = cycle;
        samp++;
      end
      phase = (phase + 1) % gap;
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    cyc();
    bif.bus_wen   = 1'b1;
    bif.bus_addr  = addr;
    bif.bus_wdata = data;
    wr_cycle      = cycle;
    exp_q.push_back('0);
    chk_q.push_back(1'b0);
    name_q.push_back("wr");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    cyc();
    bif.bus_ren  = 1'b1;
    bif.bus_addr = addr;
    exp_q.push_back(exp);
    chk_q.push_back(1'b1);
    name_q.push_back(name);
  endtask

  task automatic start_run(input int pre, input int pst, input logic [TN-1:0] mask,
                           input int ta, input int tb2, input int g, input int b,
                           input logic [31:0] ctl);
    stream_en = 0;
    wr(32'h10, pre);
    wr(32'h14, pst);
    wr(32'h04, 32'(mask));
    wr(32'h00, ctl);
    for (int i = 0; i < 64; i++) samp_cycle[i] = -100;
    samp = 0; phase = 0; gap = g; base = b;
    trg_a = ta; trg_b = tb2; trg_bits = 4'b0001;
    stream_en = 1;
  endtask

  task automatic wait_stp(input int prev, input string name);
    int n = 0;
    while (stp_cnt == prev && n < 300) begin cyc(); n++; end
    check(name, 32'(stp_cnt - prev), 1);
    stream_en = 0;
  endtask

  task automatic wait_trg(input int prev, input string name);
    int n = 0;
    while (trg_cnt == prev && n < 300) begin cyc(); n++; end
    check(name, 32'(trg_cnt - prev), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s0;
    rst = 1'b1;
    trg_ext = '0;
    bif.sti_tvalid = 1'b0;
    bif.sti_tdata  = '0;
    bif.bus_wen    = 1'b0;
    bif.bus_ren    = 1'b0;
    bif.bus_addr   = '0;
    bif.bus_wdata  = '0;
    repeat (3) cyc();
    check("rst_ack", 32'(bif.bus_ack), 0);
    check("rst_rdata", bif.bus_rdata, 0);
    check("rst_tready", 32'(bif.sti_tready), 1);
    check("rst_trg_out", 32'(trg_out), 0);
    check("rst_irq_trg", 32'(irq_trg), 0);
    check("rst_irq_stp", 32'(irq_stp), 0);
    rst = 1'b0;
    rd(32'h00, 32'h2, "rst_ctl");
    rd(32'h04, 0, "rst_cfg_trg");
    rd(32'h10, 0, "rst_cfg_pre");
    rd(32'h14, 0, "rst_cfg_pst");
    rd(32'h18, 0, "rst_trg_ptr");
    rd(32'h1c, 0, "rst_ptr");
    rd(32'h08, 0, "unmapped");

    // basic capture
    t0 = trg_cnt; s0 = stp_cnt;
    start_run(4, 3, 4'b0001, 10, -1, 1, 0, 32'h2);
    wait_stp(s0, "t1_stop");
    check("t1_ntrg", 32'(trg_cnt - t0), 1);
    check("t1_trg_cycle", 32'(trg_cycle), 32'(samp_cycle[10] + 1));
    check("t1_stp_cycle", 32'(stp_cycle), 32'(samp_cycle[13] + 1));
    rd(32'h18, 10, "t1_trg_ptr");
    rd(32'h1c, 14, "t1_ptr");
    for (int k = 10; k <= 13; k++) rd(BUF + 32'(4 * k), 32'(k), "t1_buf");
    rd(32'h00, 32'h2, "t1_idle");

    // trigger during PRE is ignored
    t0 = trg_cnt; s0 = stp_cnt;
    start_run(8, 3, 4'b0001, 3, 12, 1, 0, 32'h2);
    wait_stp(s0, "t2_stop");
    check("t2_ntrg", 32'(trg_cnt - t0), 1);
    check("t2_trg_cycle", 32'(trg_cycle), 32'(samp_cycle[12] + 1));
    rd(32'h18, 12, "t2_trg_ptr");
    rd(32'h1c, 0, "t2_ptr_wrap");
    rd(BUF + 32'(4 * 12), 12, "t2_buf12");

    // mask blocks trg_ext; software trigger (not the one sharing the start write)
    t0 = trg_cnt; s0 = stp_cnt;
    trg_hold = 4'hF;
    start_run(0, 1, 4'b0000, -1, -1, 1, 0, 32'h6);
    repeat (10) cyc();
    check("t3_masked", 32'(trg_cnt - t0), 0);
    rd(32'h00, 32'h1, "t3_running");
    wr(32'h00, 32'h4);
    wait_stp(s0, "t3_stop");
    trg_hold = '0;
    check("t3_ntrg", 32'(trg_cnt - t0), 1);
    check("t3_trg_cycle", 32'(trg_cycle), 32'(wr_cycle + 1));
    rd(32'h18, 11, "t3_trg_ptr");
    rd(32'h1c, 13, "t3_ptr");

    // wrap-around
    s0 = stp_cnt;
    start_run(20, 2, 4'b0001, 25, -1, 1, 0, 32'h2);
    wait_stp(s0, "t4_stop");
    check("t4_stp_cycle", 32'(stp_cycle), 32'(samp_cycle[27] + 1));
    rd(32'h18, 9, "t4_trg_ptr");
    rd(BUF + 32'(4 * 9), 25, "t4_buf9");
    rd(BUF + 32'(4 * 10), 26, "t4_buf10");
    rd(BUF + 32'(4 * 11), 27, "t4_buf11");
    rd(32'h1c, 12, "t4_ptr");

    // gapped stream, negative samples
    s0 = stp_cnt;
    start_run(2, 2, 4'b0001, 5, -1, 3, -8, 32'h2);
    wait_stp(s0, "t5_stop");
    check("t5_trg_cycle", 32'(trg_cycle), 32'(samp_cycle[5] + 1));
    check("t5_stp_cycle", 32'(stp_cycle), 32'(samp_cycle[7] + 1));
    rd(32'h18, 5, "t5_trg_ptr");
    rd(32'h1c, 8, "t5_ptr");
    rd(BUF + 32'(4 * 4), 32'hFFFF_FFFC, "t5_buf4");
    rd(BUF + 32'(4 * 5), 32'hFFFF_FFFD, "t5_buf5");
    rd(BUF + 32'(4 * 7), 32'hFFFF_FFFF, "t5_buf7");

    // engine reset mid-POST, then zero pre/post counts
    t0 = trg_cnt;
    start_run(0, 20, 4'b0001, 3, -1, 1, 0, 32'h2);
    wait_trg(t0, "t6_trg");
    repeat (2) cyc();
    s0 = stp_cnt;
    wr(32'h00, 32'h1);
    repeat (3) cyc();
    stream_en = 0;
    check("t6_no_stp", 32'(stp_cnt - s0), 0);
    rd(32'h00, 32'h2, "t6_idle");
    rd(32'h1c, 0, "t6_ptr_clr");
    rd(32'h14, 20, "t6_cfg_kept");
    wr(32'h00, 32'h3);
    rd(32'h00, 32'h2, "t6_rst_wins");
    t0 = trg_cnt; s0 = stp_cnt;
    start_run(0, 0, 4'b0001, 4, -1, 1, 0, 32'h2);
    wait_stp(s0, "t6_stop");
    check("t6_ntrg", 32'(trg_cnt - t0), 1);
    check("t6_stp_after_trg", 32'(stp_cycle), 32'(trg_cycle + 1));
    rd(32'h18, 4, "t6_trg_ptr");

    repeat (3) cyc();
    check("ack_drain", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
